seven_seg_mux: RTL and testbench
================================

// Module: seven_seg_mux
// PURPOSE
//   Time-multiplexed driver for NUM_DIGITS common-anode/cathode 7-segment digits, full hex (0-F).
//   Scans one digit per REFRESH_DIV clocks and double-buffers the displayed value.
//   New values are committed only at frame boundaries, so a frame never tears.
//   Inserts a per-slot anode guard interval to suppress ghosting.
//   Sits between game/score logic and the board display pins.
// PARAMETERS
//   NUM_DIGITS    4      number of digits scanned; >=1
//   REFRESH_DIV   50000  clocks per digit slot; >=2
//   GUARD         16     clocks at start of each slot with all anodes off; 0 <= GUARD < REFRESH_DIV
//   SEG_ACT_LOW   0      1: seg outputs inverted (segment on = 0)
//   AN_ACT_LOW    0      1: an outputs inverted (digit on = 0)
// PORTS
//   clk         in   1             system clock
//   rst         in   1             synchronous reset, active-high
//   load        in   1             1-cycle strobe: capture value/blank_mask/lz_blank
//   value       in   4*NUM_DIGITS  hex nibbles; digit i = value[4i+3:4i], digit 0 = rightmost/LSB
//   blank_mask  in   NUM_DIGITS    1 = force digit i dark
//   lz_blank    in   1             1 = suppress leading zeros
//   seg         out  7             {a,b,c,d,e,f,g}, polarity per SEG_ACT_LOW
//   an          out  NUM_DIGITS    one-hot digit enable, polarity per AN_ACT_LOW
//   frame_tick  out  1             1-cycle pulse when scan wraps to digit 0
//   pending     out  1             a loaded value awaits commit
// BEHAVIOUR
//   Reset: div=0, idx=0, display regs (value/mask/lz)=0, pending=0, frame_tick=0,
//     seg=all segments off, an=all digits off (off = inactive level per polarity params).
//   Scan: div counts 0..REFRESH_DIV-1, wraps to 0; at div==REFRESH_DIV-1, idx increments mod NUM_DIGITS.
//     Wrap cycle (div==REFRESH_DIV-1 && idx==NUM_DIGITS-1) is the frame boundary; frame_tick is
//     registered and high on the cycle after it.
//   Load/commit (no backpressure; load always accepted):
//     - load, not on boundary: capture into shadow regs, pending<=1; back-to-back loads overwrite the shadow.
//     - boundary, no load: if pending, display<=shadow and pending<=0.
//     - load on boundary cycle: display<=load inputs directly, pending<=0, shadow<=load inputs.
//   Digit shown in slot idx, using display regs:
//     - nib = disp_value[4idx+3:4idx];
//       hex font 0=7E 1=30 2=6D 3=79 4=33 5=5B 6=5F 7=70 8=7F 9=7B A=77 b=1F C=4E d=3D E=4F F=47.
//     - dark if disp_mask[idx].
//     - dark if disp_lz and idx!=0 and all nibbles idx..NUM_DIGITS-1 are zero. Digit 0 is never
//       lz-suppressed, so 0 displays as "0".
//   Outputs registered: seg/an reflect the div/idx of the previous cycle.
//     an = onehot(idx) unless div<GUARD or the digit is dark, in which case an is all off.
//     seg = font(nib), or all off when an is off.
//   NUM_DIGITS==1: every slot end is a frame boundary.
//   rst mid-frame or mid-pending: all state returns to reset values; pending load is discarded.
// TESTING  (NUM_DIGITS=4, REFRESH_DIV=4, GUARD=1, active-high)
//   Reset, no load -> an=0000, seg=0000000 for >=2 frames; frame_tick every 16 clks.
//   load value=16'h1A2F, mask=0, lz=0 mid-frame -> pending=1, display unchanged until boundary;
//     next frame idx0: seg=47, an=0001 for clks 2-4 of slot (guard clk dark); idx1 seg=6D, idx2 77, idx3 30.
//   load 16'h0000 then 16'h0305 before boundary -> only 0305 shown; lz=1 -> digit3 dark, digits 2,1,0 show 3,0,5.
//   lz=1, value=0 -> only digit0 lit with "0"; mask=4'b0001 -> all four dark.
//   load coincident with boundary cycle -> new value shown from the very next frame; pending stays 0.
//   rst asserted mid-slot with pending=1 -> next cycle pending=0, an=0000, seg=0, idx restarts at 0.

Source files
------------

// File: rtl/seven_seg_mux.sv
// Time-multiplexed hex driver for NUM_DIGITS seven-segment digits.
// Double-buffered display value commits at frame boundaries; per-slot anode guard suppresses ghosting.
module seven_seg_mux #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int GUARD       = 16,
    parameter int SEG_ACT_LOW = 0,
    parameter int AN_ACT_LOW  = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    input  logic                    lz_blank,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_tick,
    output logic                    pending
);

    localparam int DIV_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [DIV_W-1:0]      DIV_LAST = DIV_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    // XOR-ing an active-high pattern with the "off" level yields the pin polarity.
    localparam logic [6:0]            SEG_OFF  = (SEG_ACT_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [NUM_DIGITS-1:0] AN_OFF   = (AN_ACT_LOW != 0) ? '1 : '0;

    logic [DIV_W-1:0]        div;
    logic [IDX_W-1:0]        idx;
    logic [4*NUM_DIGITS-1:0] disp_value, shadow_value;
    logic [NUM_DIGITS-1:0]   disp_mask, shadow_mask;
    logic                    disp_lz, shadow_lz;
    logic                    boundary;
    logic [3:0]              nib;
    logic                    masked, upper_zero, dark, lit;
    logic [NUM_DIGITS-1:0]   an_n;
    logic [6:0]              seg_n;

    function automatic logic [6:0] hex_font(input logic [3:0] n);
        logic [6:0] f;
        case (n)
            4'h0: f = 7'h7E;
            4'h1: f = 7'h30;
            4'h2: f = 7'h6D;
            4'h3: f = 7'h79;
            4'h4: f = 7'h33;
            4'h5: f = 7'h5B;
            4'h6: f = 7'h5F;
            4'h7: f = 7'h70;
            4'h8: f = 7'h7F;
            4'h9: f = 7'h7B;
            4'hA: f = 7'h77;
            4'hB: f = 7'h1F;
            4'hC: f = 7'h4E;
            4'hD: f = 7'h3D;
            4'hE: f = 7'h4F;
            default: f = 7'h47;
        endcase
        return f;
    endfunction

    assign boundary = (div == DIV_LAST) && (idx == IDX_LAST);

    always_comb begin
        nib        = '0;
        masked     = 1'b0;
        upper_zero = 1'b1;
        an_n       = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (IDX_W'(i) == idx) begin
                nib     = disp_value[4*i +: 4];
                masked  = disp_mask[i];
                an_n[i] = 1'b1;
            end
            if (i >= int'(idx) && disp_value[4*i +: 4] != 4'h0)
                upper_zero = 1'b0;
        end
        // Digit 0 is exempt so an all-zero value still reads "0".
        dark  = masked || (disp_lz && idx != '0 && upper_zero);
        lit   = (int'(div) >= GUARD) && !dark;
        seg_n = lit ? hex_font(nib) : 7'h00;
        if (!lit)
            an_n = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div        <= '0;
            idx        <= '0;
            disp_value <= '0;
            disp_mask  <= '0;
            disp_lz    <= 1'b0;
            pending    <= 1'b0;
            frame_tick <= 1'b0;
            seg        <= SEG_OFF;
            an         <= AN_OFF;
        end else begin
            div <= (div == DIV_LAST) ? '0 : div + 1'b1;
            if (div == DIV_LAST)
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            frame_tick <= boundary;
            seg        <= seg_n ^ SEG_OFF;
            an         <= an_n ^ AN_OFF;
            // A load on the boundary bypasses the shadow so it is seen in the very next frame.
            if (load && boundary) begin
                disp_value <= value;
                disp_mask  <= blank_mask;
                disp_lz    <= lz_blank;
                pending    <= 1'b0;
            end else if (load) begin
                pending <= 1'b1;
            end else if (boundary && pending) begin
                disp_value <= shadow_value;
                disp_mask  <= shadow_mask;
                disp_lz    <= shadow_lz;
                pending    <= 1'b0;
            end
        end
    end

    // Shadow content is only consumed while pending is set, so it needs no reset.
    always_ff @(posedge clk) begin
        if (load) begin
            shadow_value <= value;
            shadow_mask  <= blank_mask;
            shadow_lz    <= lz_blank;
        end
    end

endmodule

// File: tb/tb_seven_seg_mux.sv
// Bench for seven_seg_mux: time-indexed behavioural model checked every cycle,
// plus literal expectations at selected scan positions.
module tb_seven_seg_mux;
    localparam int N = 4;
    localparam int R = 4;
    localparam int G = 1;

    logic         clk = 1'b0;
    logic         rst, load, lz_blank;
    logic [15:0]  value;
    logic [3:0]   blank_mask;
    logic [6:0]   seg;
    logic [3:0]   an;
    logic         frame_tick, pending;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seven_seg_mux #(
        .NUM_DIGITS(N), .REFRESH_DIV(R), .GUARD(G), .SEG_ACT_LOW(0), .AN_ACT_LOW(0)
    ) dut (
        .clk(clk), .rst(rst), .load(load), .value(value), .blank_mask(blank_mask),
        .lz_blank(lz_blank), .seg(seg), .an(an), .frame_tick(frame_tick), .pending(pending)
    );

    logic [6:0] font [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                              7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

    // Model: scan position derived from cycles elapsed since reset.
    int          t = 0;
    logic [15:0] m_val = '0, s_val = '0;
    logic [3:0]  m_mask = '0, s_mask = '0;
    logic        m_lz = 1'b0, s_lz = 1'b0, m_pend = 1'b0;
    logic [6:0]  e_seg = '0;
    logic [3:0]  e_an = '0;
    logic        e_ft = 1'b0, e_pend = 1'b0;
    int          o_idx = 0, o_div = 0;
    bit          o_valid = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0d)", nm, act, exp, t);
        end
    endtask

    task automatic model_step();
        int d, i;
        bit bnd, dark;
        if (rst) begin
            t = 0; m_val = '0; m_mask = '0; m_lz = 1'b0; m_pend = 1'b0;
            e_seg = '0; e_an = '0; e_ft = 1'b0; e_pend = 1'b0; o_valid = 1'b0;
        end else begin
            d    = t % R;
            i    = (t / R) % N;
            bnd  = (d == R - 1) && (i == N - 1);
            dark = m_mask[i] || (m_lz && i != 0 && (m_val >> (4 * i)) == 16'h0);
            if (d < G || dark) begin
                e_an  = '0;
                e_seg = '0;
            end else begin
                e_an  = 4'(1 << i);
                e_seg = font[4'((m_val >> (4 * i)) & 16'hF)];
            end
            e_ft = bnd; o_idx = i; o_div = d; o_valid = 1'b1;
            if (load) begin
                s_val = value; s_mask = blank_mask; s_lz = lz_blank;
                if (bnd) begin
                    m_val = value; m_mask = blank_mask; m_lz = lz_blank; m_pend = 1'b0;
                end else begin
                    m_pend = 1'b1;
                end
            end else if (bnd && m_pend) begin
                m_val = s_val; m_mask = s_mask; m_lz = s_lz; m_pend = 1'b0;
            end
            e_pend = m_pend;
            t++;
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        check("seg", 32'(seg), 32'(e_seg));
        check("an", 32'(an), 32'(e_an));
        check("frame_tick", 32'(frame_tick), 32'(e_ft));
        check("pending", 32'(pending), 32'(e_pend));
    end

    // Wait until the outputs on the pins belong to slot (i,d).
    task automatic wait_pos(input int i, input int d);
        int n = 0;
        while (!(o_valid && o_idx == i && o_div == d) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++; errors++;
            $display("FAIL wait_pos: slot %0d/%0d not reached, got %0d/%0d", i, d, o_idx, o_div);
        end
    endtask

    // Wait until the next rising edge will sample the DUT at slot (i,d).
    task automatic wait_next(input int i, input int d);
        int n = 0;
        while (!(t % R == d && (t / R) % N == i) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++; errors++;
            $display("FAIL wait_next: slot %0d/%0d not reached", i, d);
        end
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] m, input logic lz);
        value = v; blank_mask = m; lz_blank = lz; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic lit(input string nm, input logic [6:0] s, input logic [3:0] a);
        check({nm, "_seg"}, 32'(seg), 32'(s));
        check({nm, "_an"}, 32'(an), 32'(a));
    endtask

    initial begin
        int cnt, first;
        logic [15:0] v;
        rst = 1'b1; load = 1'b0; value = '0; blank_mask = '0; lz_blank = 1'b0;
        repeat (3) @(negedge clk);
        lit("reset", 7'h00, 4'b0000);
        check("reset_pending", 32'(pending), 32'd0);
        check("reset_ft", 32'(frame_tick), 32'd0);
        rst = 1'b0;

        cnt = 0;
        repeat (32) begin
            @(negedge clk);
            cnt += int'(frame_tick);
        end
        check("ft_two_frames", 32'(cnt), 32'd2);

        // Mid-frame load commits at the next boundary.
        wait_next(1, 0);
        do_load(16'h1A2F, 4'b0000, 1'b0);
        check("pending_after_load", 32'(pending), 32'd1);
        wait_pos(0, 0); lit("guard", 7'h00, 4'b0000);
        check("pending_committed", 32'(pending), 32'd0);
        wait_pos(0, 1); lit("d0_F", 7'h47, 4'b0001);
        wait_pos(1, 1); lit("d1_2", 7'h6D, 4'b0010);
        wait_pos(2, 1); lit("d2_A", 7'h77, 4'b0100);
        wait_pos(3, 1); lit("d3_1", 7'h30, 4'b1000);

        // Back-to-back loads: only the last one is shown; leading zero suppressed.
        wait_next(1, 0);
        value = 16'h0000; blank_mask = '0; lz_blank = 1'b1; load = 1'b1;
        @(negedge clk);
        do_load(16'h0305, 4'b0000, 1'b1);
        wait_pos(0, 1); lit("lz_d0_5", 7'h5B, 4'b0001);
        wait_pos(1, 1); lit("lz_d1_0", 7'h7E, 4'b0010);
        wait_pos(2, 1); lit("lz_d2_3", 7'h79, 4'b0100);
        wait_pos(3, 1); lit("lz_d3_dark", 7'h00, 4'b0000);

        wait_next(1, 0);
        do_load(16'h0000, 4'b0000, 1'b1);
        wait_pos(0, 1); lit("zero_d0", 7'h7E, 4'b0001);
        wait_pos(1, 1); lit("zero_d1", 7'h00, 4'b0000);
        wait_pos(3, 1); lit("zero_d3", 7'h00, 4'b0000);

        wait_next(1, 0);
        do_load(16'h0000, 4'b0001, 1'b1);
        wait_pos(0, 1); lit("mask_d0", 7'h00, 4'b0000);
        wait_pos(2, 1); lit("mask_d2", 7'h00, 4'b0000);

        // Load sampled exactly on the boundary edge.
        wait_next(3, 3);
        do_load(16'h8888, 4'b0000, 1'b0);
        check("bnd_pending", 32'(pending), 32'd0);
        check("bnd_ft", 32'(frame_tick), 32'd1);
        wait_pos(0, 1); lit("bnd_d0", 7'h7F, 4'b0001);

        // Reset while a load is pending discards it.
        wait_next(1, 1);
        do_load(16'h1234, 4'b0000, 1'b0);
        check("rst_pre_pending", 32'(pending), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_pending", 32'(pending), 32'd0);
        lit("rst_mid", 7'h00, 4'b0000);
        first = 0;
        for (int k = 1; k <= 20 && first == 0; k++) begin
            @(negedge clk);
            if (frame_tick) first = k;
        end
        check("rst_first_ft", 32'(first), 32'd16);
        wait_pos(0, 1); lit("rst_discard", 7'h7E, 4'b0001);

        // Randomized traffic, including occasional reset.
        for (int k = 0; k < 800; k++) begin
            v = 16'($urandom);
            for (int b = 0; b < 4; b++)
                if ($urandom_range(0, 1) == 0) v[4*b +: 4] = 4'h0;
            value      = v;
            blank_mask = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
            lz_blank   = 1'($urandom_range(0, 1));
            load       = ($urandom_range(0, 6) == 0);
            rst        = ($urandom_range(0, 249) == 0);
            @(negedge clk);
        end
        rst = 1'b0; load = 1'b0;
        repeat (40) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
